bitty_exec_ctrl: RTL

Multi-cycle execute controller that sits directly upstream of the 16-bit BittyPro ALU and also consumes its result.
- Accepts one 16-bit instruction over a valid/ready handshake.
- Reads two operands from an internal 8x16 register file and drives the ALU's operand, mode/select and carry_in inputs.
- Captures alu_out, carry_out and compare, then writes the result back and updates the carry and equal flags.
- Provides the sequencing, operand buffering and flag state that the combinational ALU lacks.

---
 rtl/bitty_pkg.sv | 24 ++
 rtl/bitty_regfile.sv | 34 +++
 rtl/bitty_exec_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bitty_pkg.sv
// Shared types and constants for the BittyPro execute controller.
package bitty_pkg;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

  localparam logic [1:0] FMT_ALU = 2'b00;
  localparam logic [1:0] FMT_LDI = 2'b01;
  localparam logic [1:0] FMT_CMP = 2'b10;
  localparam logic [1:0] FMT_ILL = 2'b11;

  // Instruction field positions
  localparam int RX_LSB  = 13;
  localparam int RY_LSB  = 10;
  localparam int MODE_B  = 9;
  localparam int SEL_LSB = 5;
  localparam int IMM_LSB = 5;
  localparam int IMM_W   = 8;
  localparam int UC_B    = 4;
  localparam int RSV_LSB = 2;
  localparam int FMT_LSB = 0;
endpackage

// File: rtl/bitty_regfile.sv
// NUM_REGS x DATA_W register file: two async operand reads, debug read, one sync write.
module bitty_regfile
  import bitty_pkg::*;
#(
  parameter int NUM_REGS = bitty_pkg::NUM_REGS,
  parameter int DATA_W   = bitty_pkg::DATA_W,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);
  logic [DATA_W-1:0] rf_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = rf_q[raddr_a_i];
  assign rdata_b_o  = rf_q[raddr_b_i];
  assign dbg_data_o = rf_q[dbg_addr_i];
endmodule

// File: rtl/bitty_exec_ctrl.sv
// Four-state execute controller wrapped around the external combinational BittyPro ALU.
module bitty_exec_ctrl
  import bitty_pkg::*;
#(
  parameter int NUM_REGS = bitty_pkg::NUM_REGS,
  parameter int DATA_W   = bitty_pkg::DATA_W,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_mode,
  output logic [3:0]        alu_select,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry_out,
  input  logic              alu_compare,
  output logic              done,
  output logic              carry_flag,
  output logic              eq_flag,
  output logic              illegal,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  state_e            state_q, state_d;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] reg_a_q, reg_b_q, result_q;
  logic              cout_q, cmp_q, carry_q, eq_q;
  logic [DATA_W-1:0] rd_a, rd_b, wdata;
  logic              we;

  logic [AW-1:0] rx, ry;
  logic [1:0]    fmt;
  logic          mode, use_carry, unused_rsvd;
  assign rx          = ir_q[RX_LSB +: AW];
  assign ry          = ir_q[RY_LSB +: AW];
  assign mode        = ir_q[MODE_B];
  assign use_carry   = ir_q[UC_B];
  assign fmt         = ir_q[FMT_LSB +: 2];
  assign unused_rsvd = ^ir_q[RSV_LSB +: 2];

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_READ;
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB: begin
        done    = 1'b1;
        illegal = (fmt == FMT_ILL);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Flags move only in S_WB, so a reset before then leaves no architectural trace.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_q     <= '0;
      reg_a_q  <= '0;
      reg_b_q  <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      cmp_q    <= 1'b0;
      carry_q  <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (instr_valid) ir_q <= instr;
        S_READ: begin
          reg_a_q <= rd_a;
          reg_b_q <= rd_b;
        end
        S_EXEC: begin
          result_q <= alu_out;
          cout_q   <= alu_carry_out;
          cmp_q    <= alu_compare;
        end
        S_WB: begin
          if (fmt == FMT_ALU || fmt == FMT_CMP) begin
            eq_q <= cmp_q;
            if (!mode) carry_q <= cout_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign we    = (state_q == S_WB) && (fmt == FMT_ALU || fmt == FMT_LDI);
  assign wdata = (fmt == FMT_LDI) ? DATA_W'(ir_q[IMM_LSB +: IMM_W]) : result_q;

  bitty_regfile #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_rf (
    .clk        (clk),
    .reset_n    (reset_n),
    .we_i       (we),
    .waddr_i    (rx),
    .wdata_i    (wdata),
    .raddr_a_i  (rx),
    .rdata_a_o  (rd_a),
    .raddr_b_i  (ry),
    .rdata_b_o  (rd_b),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  assign alu_a        = reg_a_q;
  assign alu_b        = reg_b_q;
  assign alu_mode     = mode;
  assign alu_select   = ir_q[SEL_LSB +: 4];
  assign alu_carry_in = use_carry & carry_q;
  assign carry_flag   = carry_q;
  assign eq_flag      = eq_q;
endmodule
